// File: rtl/idli_mem_pkg.sv
// Shared types and defaults for the idli memory arbiter: FSM states, owner encoding, widths.
package idli_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    // Wide enough for the largest allowed streak limit (15).
    localparam int STREAK_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/idli_mem_arb_pick.sv
// Winner select between fetch and data requests, plus the next value of the data-streak counter.
module idli_mem_arb_pick
    import idli_mem_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                f_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant,
    output logic                grant_data,
    output logic [STREAK_W-1:0] streak_nxt
);

    localparam logic [STREAK_W-1:0] MAX_S  = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [STREAK_W-1:0] SAT_S  = '1;

    always_comb begin
        grant      = f_req | d_req;
        // Data normally wins a contest; fetch wins once data has had MAX_S contested grants in a row.
        grant_data = d_req && !(f_req && (streak == MAX_S));
        streak_nxt = streak;
        if (grant) begin
            if (grant_data && f_req) begin
                streak_nxt = (streak == SAT_S) ? streak : streak + 1'b1;
            end else begin
                streak_nxt = '0;
            end
        end
    end

endmodule

// File: rtl/idli_mem_arb.sv
// Shares one QSPI memory controller between the fetch and load/store ports, one transaction at a time.
// Handshake: a port holds req (with addr/wdata stable) until its one-cycle ack; req still high after the ack is a new request.
module idli_mem_arb
    import idli_mem_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_start,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_busy,
    input  logic              m_done,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              owner,
    output logic              err,
    output logic [1:0]        dbg_state
);

    arb_state_t          state, state_nxt;
    owner_t              owner_q;
    logic [STREAK_W-1:0] streak, streak_nxt;
    logic                grant, grant_data;

    idli_mem_arb_pick #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_pick (
        .f_req     (f_req),
        .d_req     (d_req),
        .streak    (streak),
        .grant     (grant),
        .grant_data(grant_data),
        .streak_nxt(streak_nxt)
    );

    always_comb begin
        state_nxt = state;
        m_start   = 1'b0;
        case (state)
            IDLE:  if (grant) state_nxt = START;
            START: begin
                if (!m_busy) begin
                    m_start   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT:  if (m_done) state_nxt = ACK;
            ACK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign f_ack     = (state == ACK) && (owner_q == OWN_FETCH);
    assign d_ack     = (state == ACK) && (owner_q == OWN_DATA);
    assign owner     = owner_q;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner_q <= OWN_FETCH;
            streak  <= '0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            f_rdata <= '0;
            d_rdata <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && grant) begin
                streak <= streak_nxt;
                if (grant_data) begin
                    owner_q <= OWN_DATA;
                    m_we    <= d_we;
                    m_addr  <= d_addr;
                    m_wdata <= d_wdata;
                end else begin
                    owner_q <= OWN_FETCH;
                    m_we    <= 1'b0;
                    m_addr  <= f_addr;
                    m_wdata <= '0;
                end
            end
            // A done pulse is only meaningful while a transaction is outstanding.
            if (m_done) begin
                if (state == WAIT) begin
                    if (!m_we) begin
                        if (owner_q == OWN_DATA) d_rdata <= m_rdata;
                        else                     f_rdata <= m_rdata;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
